mem_dato_arbiter: RTL
=====================

Name: mem_dato_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the CPU load/store stage and port 1 is the debug/DMA loader.
- Arbitrates with round-robin priority and drives the memory's Address, WriteData, MemWrite and MemRead.
- Sequences around the memory's registered (1-cycle) read and returns the read data to the winning port with a valid pulse.

Parameters:
- DATA_W, 32, data width of WriteData and MemRes.
- ADDR_W, 32, address width.
- MEM_DEPTH, 32, number of memory words; used by the optional bounds check.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Req0  in  1  port 0 request.
- We0  in  1  port 0: 1 = write, 0 = read.
- Addr0  in  ADDR_W  port 0 word address.
- WData0  in  DATA_W  port 0 write data.
- Gnt0  out  1  port 0 grant, 1-cycle pulse.
- RValid0  out  1  port 0 read data valid, 1-cycle pulse.
- RData0  out  DATA_W  port 0 read data.
- Req1, We1, Addr1, WData1, Gnt1, RValid1, RData1  same as port 0, for port 1.
- MemAddress  out  ADDR_W  to memory Address.
- MemWriteData  out  DATA_W  to memory WriteData.
- MemWrite  out  1  to memory MemWrite.
- MemRead  out  1  to memory MemRead.
- MemRes  in  DATA_W  from memory; valid the cycle after MemRead.
- AddrErr  out  1  out-of-range access pulse (optional feature only).

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; round-robin pointer favours port 0.
  - All outputs are 0: Gnt*, RValid*, RData*, Mem*, AddrErr.
  - Any in-flight read is dropped; no RValid follows.
- States:
  - IDLE: if any Req is high, latch the winner's We/Addr/WData, go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: exactly one cycle. Gnt of the winner = 1. MemRead = !We or MemWrite = We. Next state is RESP for a read, IDLE for a write.
  - RESP: MemRes is valid. At the closing edge, RData<winner> <= MemRes and RValid<winner> <= 1 (visible the next cycle). Next state is IDLE.
- Timing, read requested in cycle T:
  - Gnt and MemRead in T+1.
  - RValid and RData in T+3.
  - Earliest next ACCESS in T+4.
- Timing, write requested in cycle T:
  - Gnt and MemWrite in T+1.
  - Earliest next ACCESS in T+3.
- Requester rules:
  - Hold Req/We/Addr/WData stable until Gnt is seen.
  - Deassert Req at the edge closing the Gnt cycle.
  - Req still high in a later IDLE cycle counts as a new request.
- Arbitration:
  - One requester: it wins.
  - Both requesting: the port indicated by the pointer wins.
  - The pointer moves to the other port after every grant.
  - The pointer does not change when there is no grant.
- MemAddress/MemWriteData update only on entering ACCESS and hold afterwards. MemWrite and MemRead are never high together and are high only in ACCESS.
- RData<n> holds its value until the next read by port n completes.
- Requests arriving in ACCESS or RESP are not sampled until IDLE.

Optional Feature:
- Macro: MEMARB_BOUNDS_CHECK_EN.
- Defined: for an access with latched address >= MEM_DEPTH:
  - Gnt is still pulsed.
  - MemRead/MemWrite stay 0, so memory is untouched.
  - AddrErr pulses in the ACCESS cycle.
  - A read still passes through RESP and returns RData = 0 with RValid.
- Undefined: addresses are forwarded unchanged and AddrErr is tied to 0.

Test Plan:
- Memory model preset mem[i] = i.
- Port 0 reads addr 5 -> Gnt0 and MemRead in T+1, MemAddress = 5; RValid0 = 1 and RData0 = 5 in T+3; port 1 outputs stay 0.
- Port 1 writes 0xDEAD_BEEF to addr 7, then reads addr 7 -> MemWrite 1 cycle, then RData1 = 0xDEADBEEF.
- Req0 and Req1 reads both held continuously from reset -> grants alternate 0,1,0,1; RData values match addresses; never two Gnts in one cycle.
- rst_n low during RESP of a port 0 read -> all outputs 0 immediately; no RValid0 after release; next simultaneous request grants port 0.
- With MEMARB_BOUNDS_CHECK_EN, port 0 reads addr 40 -> Gnt0, AddrErr pulse, MemRead = 0, RData0 = 0 with RValid0; a write to addr 40 leaves memory unchanged.

Source files
------------

// File: rtl/mem_dato_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU (port 0) and a debug/DMA loader (port 1).
// Define MEMARB_BOUNDS_CHECK_EN to suppress and flag accesses whose address is >= MEM_DEPTH.
module mem_dato_arbiter #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Req0,
    input  logic              We0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] WData0,
    output logic              Gnt0,
    output logic              RValid0,
    output logic [DATA_W-1:0] RData0,
    input  logic              Req1,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData1,
    output logic              Gnt1,
    output logic              RValid1,
    output logic [DATA_W-1:0] RData1,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] MemRes,
    output logic              AddrErr
);

`ifdef MEMARB_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                rr_q, rr_d;       // 0: port 0 wins a tie, 1: port 1 wins a tie
    logic                win_q, win_d;
    logic                we_q, we_d;
    logic                oob_q, oob_d;
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                rvalid0_q, rvalid0_d;
    logic                rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                addr_err_q, addr_err_d;

    logic                pick;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_oob;

    // Winner selection: a lone requester wins, a tie goes to the round-robin pointer.
    always_comb begin
        pick      = (Req0 && Req1) ? rr_q : Req1;
        sel_we    = pick ? We1 : We0;
        sel_addr  = pick ? Addr1 : Addr0;
        sel_wdata = pick ? WData1 : WData0;
        sel_oob   = BOUNDS_EN && (sel_addr >= ADDR_W'(MEM_DEPTH));
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        win_d       = win_q;
        we_d        = we_q;
        oob_d       = oob_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        addr_err_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Req0 || Req1) begin
                    state_d     = ACCESS;
                    win_d       = pick;
                    rr_d        = ~pick;
                    we_d        = sel_we;
                    oob_d       = sel_oob;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    gnt0_d      = ~pick;
                    gnt1_d      = pick;
                    mem_rd_d    = ~sel_we & ~sel_oob;
                    mem_wr_d    = sel_we & ~sel_oob;
                    addr_err_d  = sel_oob;
                end
            end
            ACCESS: begin
                state_d = we_q ? IDLE : RESP;
            end
            RESP: begin
                // Memory output is valid now; capture it for the winning port.
                state_d = IDLE;
                if (win_q) begin
                    rvalid1_d = 1'b1;
                    rdata1_d  = oob_q ? '0 : MemRes;
                end else begin
                    rvalid0_d = 1'b1;
                    rdata0_d  = oob_q ? '0 : MemRes;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            win_q       <= 1'b0;
            we_q        <= 1'b0;
            oob_q       <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            win_q       <= win_d;
            we_q        <= we_d;
            oob_q       <= oob_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign Gnt0         = gnt0_q;
    assign Gnt1         = gnt1_q;
    assign RValid0      = rvalid0_q;
    assign RValid1      = rvalid1_q;
    assign RData0       = rdata0_q;
    assign RData1       = rdata1_q;
    assign MemAddress   = mem_addr_q;
    assign MemWriteData = mem_wdata_q;
    assign MemRead      = mem_rd_q;
    assign MemWrite     = mem_wr_q;
    assign AddrErr      = addr_err_q;

endmodule
